// File: rtl/race_tick_scheduler.sv
// Game-speed scheduler: gates the base rate divider, turns base ticks into step strobes and ramps difficulty.
// Optional feature: define RACE_BOOST_EN to add the boost input (halves the effective step period in RUN).
module race_tick_scheduler #(
  parameter int PERIOD_W        = 4,
  parameter int START_PERIOD    = 8,
  parameter int MIN_PERIOD      = 2,
  parameter int STEPS_PER_LEVEL = 16,
  parameter int LEVEL_W         = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               pause,
  input  logic               crash,
  input  logic               tick_in,
`ifdef RACE_BOOST_EN
  input  logic               boost,
`endif
  output logic               div_enable,
  output logic               step_pulse,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         state_out
);

  localparam int                  STEP_W    = $clog2(STEPS_PER_LEVEL + 1);
  localparam logic [PERIOD_W-1:0] START_P   = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEPS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0]  MAX_LEVEL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    CRASHED = 2'd3
  } state_t;

  state_t              state;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] eff_period;
  logic [STEP_W-1:0]   step_cnt;
  logic                fire;

`ifdef RACE_BOOST_EN
  logic [PERIOD_W-1:0] half_period;

  assign half_period = period >> 1;

  always_comb begin
    eff_period = period;
    if (boost && state == RUN) begin
      eff_period = (half_period == '0) ? PERIOD_W'(1) : half_period;
    end
  end
`else
  assign eff_period = period;
`endif

  // >= rather than == so a period that shrinks mid-count fires on the next tick instead of wrapping.
  assign fire = (tick_cnt >= eff_period - PERIOD_W'(1));

  assign state_out = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      div_enable <= 1'b0;
      step_pulse <= 1'b0;
      level      <= '0;
      period     <= START_P;
      tick_cnt   <= '0;
      step_cnt   <= '0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        // CRASHED keeps level and counters visible for the score display until restart.
        IDLE, CRASHED: begin
          if (start) begin
            state      <= RUN;
            div_enable <= 1'b1;
            level      <= '0;
            period     <= START_P;
            tick_cnt   <= '0;
            step_cnt   <= '0;
          end else begin
            div_enable <= 1'b0;
          end
        end
        RUN: begin
          if (crash) begin
            state      <= CRASHED;
            div_enable <= 1'b0;
          end else if (pause) begin
            state      <= PAUSED;
            div_enable <= 1'b0;
          end else begin
            div_enable <= 1'b1;
            if (tick_in) begin
              if (fire) begin
                step_pulse <= 1'b1;
                tick_cnt   <= '0;
                if (step_cnt == STEP_LAST) begin
                  step_cnt <= '0;
                  if (level != MAX_LEVEL) level <= level + LEVEL_W'(1);
                  if (period > MIN_P) period <= period - PERIOD_W'(1);
                end else begin
                  step_cnt <= step_cnt + STEP_W'(1);
                end
              end else begin
                tick_cnt <= tick_cnt + PERIOD_W'(1);
              end
            end
          end
        end
        PAUSED: begin
          if (crash) begin
            state      <= CRASHED;
            div_enable <= 1'b0;
          end else if (!pause) begin
            state      <= RUN;
            div_enable <= 1'b1;
          end else begin
            div_enable <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
